// File: rtl/cesa_pkg.sv
// Shared definitions for the carry-estimating adder: FSM states, slice width
// and the carry-estimate function used by both the datapath and controller.
package cesa_pkg;

    localparam int CESA_SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } cesa_state_t;

    // Carry estimate into slice k from the upper nibble (bits 7..4) of slice k-1.
    // Look two bits down when the top two bits both propagate.
    function automatic logic cesa_est(input logic [3:0] a_hi, input logic [3:0] b_hi);
        logic [3:0] g;
        logic [3:0] p;
        g = a_hi & b_hi;
        p = a_hi ^ b_hi;
        if (p[3] && p[2])
            return g[1] | (p[1] & g[0]);
        else
            return g[3] | (p[3] & g[2]);
    endfunction

endpackage

// File: rtl/cesa_slice8.sv
// One 8-bit add slice: sum and carry-out from operands and a carry-in.
module cesa_slice8
    import cesa_pkg::*;
(
    input  logic [CESA_SLICE_W-1:0] i_a,
    input  logic [CESA_SLICE_W-1:0] i_b,
    input  logic                    i_ci,
    output logic [CESA_SLICE_W-1:0] o_sum,
    output logic                    o_co
);

    // Plain ripple add, one extra bit for the carry-out.
    assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CESA_SLICE_W{1'b0}}, i_ci};

endmodule

// File: rtl/cesa_add_seq.sv
// Sequencing controller for the carry-estimating adder: captures a request,
// evaluates with estimated slice carries, repairs wrong carries until the
// result is exact (or returns the first result in approx mode).
module cesa_add_seq
    import cesa_pkg::*;
#(
    parameter int NSLICE = 4,
    parameter int STATW  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [CESA_SLICE_W*NSLICE-1:0] req_a_i,
    input  logic [CESA_SLICE_W*NSLICE-1:0] req_b_i,
    input  logic                           req_cin_i,
    input  logic                           req_approx_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [CESA_SLICE_W*NSLICE-1:0] rsp_sum_o,
    output logic                           rsp_cout_o,
    output logic                           rsp_err_o,
    output logic [1:0]                     rsp_fix_o,
    output logic [STATW-1:0]               stat_fix_o
);

    localparam int W = CESA_SLICE_W * NSLICE;

    cesa_state_t       r_state, w_state_nxt;
    logic [W-1:0]      r_a, r_b;
    logic              r_approx;
    logic [NSLICE-1:0] r_ci;
    logic [1:0]        r_fix;
    logic              r_rsp_valid, r_cout, r_err;
    logic [W-1:0]      r_sum;
    logic [1:0]        r_rsp_fix;
    logic [STATW-1:0]  r_stat;

    logic [W-1:0]      w_sum;
    logic [NSLICE-1:0] w_co, w_mis, w_est, w_ci_fix;
    logic              w_any_mis, w_acc, w_fin, w_fix, w_rsp_hs;

    // Slice datapath, always fed from the captured operands and carry vector.
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        cesa_slice8 u_slice (
            .i_a  (r_a[k*CESA_SLICE_W +: CESA_SLICE_W]),
            .i_b  (r_b[k*CESA_SLICE_W +: CESA_SLICE_W]),
            .i_ci (r_ci[k]),
            .o_sum(w_sum[k*CESA_SLICE_W +: CESA_SLICE_W]),
            .o_co (w_co[k])
        );
    end

    // Initial carry estimates, mismatch vector and repaired carry vector.
    always_comb begin
        w_est    = '0;
        w_mis    = '0;
        w_ci_fix = r_ci;
        w_est[0] = req_cin_i;
        for (int k = 1; k < NSLICE; k++) begin
            w_est[k]    = cesa_est(req_a_i[(k-1)*CESA_SLICE_W+4 +: 4],
                                   req_b_i[(k-1)*CESA_SLICE_W+4 +: 4]);
            w_mis[k]    = r_ci[k] ^ w_co[k-1];
            w_ci_fix[k] = w_co[k-1];
        end
    end

    assign w_any_mis = |w_mis;
    assign w_acc     = (r_state == ST_IDLE) && req_valid_i;
    assign w_fin     = (r_state == ST_EVAL) && (!w_any_mis || r_approx);
    assign w_fix     = (r_state == ST_EVAL) && w_any_mis && !r_approx;
    assign w_rsp_hs  = (r_state == ST_DONE) && rsp_ready_i;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc)    w_state_nxt = ST_EVAL;
            ST_EVAL: if (w_fin)    w_state_nxt = ST_DONE;
            ST_DONE: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand capture on accept; carry repair and fix count while evaluating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_approx <= 1'b0;
            r_ci     <= '0;
            r_fix    <= '0;
        end else if (w_acc) begin
            r_a      <= req_a_i;
            r_b      <= req_b_i;
            r_approx <= req_approx_i;
            r_ci     <= w_est;
            r_fix    <= '0;
        end else if (w_fix) begin
            r_ci     <= w_ci_fix;
            r_fix    <= r_fix + 2'd1;
        end
    end

    // Response registers: loaded when evaluation finishes, held until taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_fix   <= '0;
        end else if (w_fin) begin
            r_rsp_valid <= 1'b1;
            r_sum       <= w_sum;
            r_cout      <= w_co[NSLICE-1];
            r_err       <= r_approx & w_any_mis;
            r_rsp_fix   <= r_fix;
        end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating count of exact-mode ops that needed at least one fix.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stat <= '0;
        else if (w_fin && !r_approx && (r_fix != 2'd0) && (r_stat != {STATW{1'b1}}))
            r_stat <= r_stat + 1'b1;
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_sum_o   = r_sum;
    assign rsp_cout_o  = r_cout;
    assign rsp_err_o   = r_err;
    assign rsp_fix_o   = r_rsp_fix;
    assign stat_fix_o  = r_stat;

endmodule

// File: doc/cesa_add_seq.md
# cesa_add_seq

Sequencing controller for a 32-bit carry-estimating adder built from four 8-bit add slices. Slice carry-ins start from per-slice carry estimates. The controller detects wrong estimates and re-evaluates with corrected carries until the result is exact. It returns the sum over a valid/ready handshake. It sits between the integer issue logic and the adder datapath, and trades variable latency (1–4 evaluation cycles) for a short critical path.

## Interface
- `NSLICE`, default 4: number of 8-bit slices; operand width `W = 8*NSLICE`.
- `STATW`, default 16: width of the fix-statistics counter.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_a_i` in W: operand A.
- `req_b_i` in W: operand B.
- `req_cin_i` in 1: carry-in to slice 0.
- `req_approx_i` in 1: 1 = return the first (speculative) result, no correction.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_sum_o` out W: sum.
- `rsp_cout_o` out 1: carry-out of the top slice.
- `rsp_err_o` out 1: approx mode only; 1 = the returned result used at least one wrong carry.
- `rsp_fix_o` out 2: number of fix cycles spent (0..NSLICE-1).
- `stat_fix_o` out STATW: saturating count of exact-mode ops with `rsp_fix_o` ≠ 0.

## Operation
- **States**
  - IDLE → EVAL on request handshake.
  - EVAL → EVAL when a fix is needed (exact mode).
  - EVAL → DONE when consistent, or on the first evaluation in approx mode.
  - DONE → IDLE on response handshake.
- **Handshake and capture**
  - `req_ready_o` = (state == IDLE).
  - On the request handshake, register A, B, cin and approx; clear the fix count.
- **Carry-in vector `ci[0..NSLICE-1]`**
  - `ci[0]` = cin.
  - For k ≥ 1, `ci[k]` is loaded on accept with the estimate computed from slice k-1's operand bits 7..4.
  - Let g_i = a_i&b_i and p_i = a_i^b_i.
  - If p7&p6: est = g5 | (p5&g4).
  - Otherwise: est = g7 | (p7&g6).
- **Each EVAL cycle**
  - All slices add combinationally using `ci`, producing slice sums and couts `co[k]`.
  - Mismatch vector: `m[k] = ci[k] ^ co[k-1]`, for k = 1..NSLICE-1.
  - If `m` = 0 or approx: register the sum, `co[NSLICE-1]`, `rsp_err_o` = |m (forced 0 in exact mode) and the fix count, then go to DONE.
  - Otherwise: `ci[k] <= co[k-1]` for all k ≥ 1, increment the fix count, and stay in EVAL.
  - Correct carries move at least one slice per fix, so exact mode converges in ≤ NSLICE-1 fixes. The exact result equals (A+B+cin) mod 2^W, with cout = bit W.
- **Statistics**
  - `stat_fix_o` increments at the EVAL→DONE transition when not approx and fix count ≠ 0.
  - It saturates at all-ones.
- **Response**
  - `rsp_*` are registered and held stable while `rsp_valid_o` && !`rsp_ready_i`.

## Timing
- Request accepted at edge E: `rsp_valid_o` rises after edge E+1+F (F = fix count). Minimum latency is 2 edges; maximum is NSLICE+1 edges.
- No back-to-back acceptance: the next `req_ready_o` goes high in the cycle after the response handshake.
- Reset (asynchronous, any state, including mid-EVAL):
  - state → IDLE.
  - `req_ready_o` reads 1 once released.
  - `rsp_valid_o`, `rsp_sum_o`, `rsp_cout_o`, `rsp_err_o`, `rsp_fix_o` and `stat_fix_o` all → 0.
  - The in-flight operation is discarded, with no response.
- Request inputs are ignored outside IDLE.
- `rsp_ready_i` is ignored outside DONE.

## Structure
- **Shared package (`cesa_pkg`)**
  - State enum (IDLE/EVAL/DONE).
  - Constant `CESA_SLICE_W` = 8.
  - The carry-estimate function, so the combinational adder and this controller use one definition.
- **Sub-module `cesa_slice8`**
  - 8-bit ripple slice: a, b, ci → sum, co.
  - Instantiated NSLICE times via generate.
- The controller holds the FSM, operand/carry registers, mismatch logic, response registers and the counter.

## Test plan
Exact mode (approx = 0) unless stated; stall-free unless stated.

- **No fix:** A=0x00000001, B=0x00000002, cin=0 → sum 0x00000003, cout 0, fix 0, `rsp_valid_o` 2 edges after accept, stat unchanged.
- **Single fix:** A=0x000000FF, B=0x00000001 → slice-1 estimate 0 is wrong → sum 0x00000100, fix 1, latency 3 edges, stat +1.
- **Worst-case ripple:** A=0x00FFFFFF, B=0x00000001 → sum 0x01000000, fix 3, latency 5 edges. Then A=0xFFFFFFFF, B=0x00000000, cin=1 → sum 0x00000000, cout 1.
- **Approx mode:** A=0x00FFFFFF, B=0x00000001, approx=1 → sum 0x00FFFF00, err 1, fix 0, latency 2 edges, stat unchanged.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles after `rsp_valid_o` → outputs stable, `req_ready_o`=0 throughout. Release → IDLE next cycle, then a new request is accepted.
- **Reset mid-operation:** assert `rst_i` during the second EVAL cycle of the worst-case op → all outputs 0 immediately. No response ever appears. Counter saturation is checked with STATW=2 after 4 fixing ops → `stat_fix_o`=3.
